// File: rtl/stream_mux_arb_pkg.sv
// Shared helpers for the stream_mux_arb slice: selector width derivation.
package stream_mux_arb_pkg;

    // Selector width for n channels, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_arb_if.sv
// Bundle of the N input streams and the single output stream of stream_mux_arb.
interface stream_mux_arb_if
    import stream_mux_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = clog2_min1(N);

    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational one-hot arbiter: first requester at or after i_ptr (wrapping) wins; RR=0 pins the start at 0.
module stream_mux_arb_rr_arbiter
    import stream_mux_arb_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int RR = 1,
    localparam int SW = clog2_min1(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);
    localparam logic [N-1:0] LP_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [SW-1:0] w_start;
    logic [N-1:0]  w_rot;
    logic [N-1:0]  w_pick;

    function automatic logic [SW-1:0] wrap_idx(input int k);
        return SW'(k % N);
    endfunction

    assign w_start = (RR != 0) ? i_ptr : '0;

    // Rotate so the search start sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        w_rot = '0;
        for (int j = 0; j < N; j++) begin
            w_rot[j] = i_req[wrap_idx(j + int'(w_start))];
        end
        w_pick = w_rot & (~w_rot + LP_ONE);
        o_gnt  = '0;
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = w_pick[wrap_idx(i + N - int'(w_start))];
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-to-1 stream multiplexer with a registered output stage and fixed-priority or round-robin arbitration.
module stream_mux_arb
    import stream_mux_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int RR = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_mux_arb_if.slave io_bus
);
    localparam int SW = clog2_min1(N);
    localparam logic [SW-1:0] LP_LAST = SW'(N - 1);

    logic [SW-1:0] r_ptr;
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;

    logic [N-1:0]  w_gnt;
    logic [N-1:0]  w_in_ready;
    logic          w_can_load;
    logic          w_load;
    logic [W-1:0]  w_mux_data;
    logic [SW-1:0] w_mux_sel;
    logic [SW-1:0] w_ptr_next;

    stream_mux_arb_rr_arbiter #(
        .N  (N),
        .RR (RR)
    ) u_arb (
        .i_req (io_bus.in_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    assign w_can_load = !r_out_valid || io_bus.out_ready;
    // Masked during reset so no producer sees a handshake the register cannot take.
    assign w_in_ready = (rst_n && w_can_load) ? w_gnt : '0;
    assign w_load     = |(io_bus.in_valid & w_in_ready);

    // AND-OR select: the grant is one-hot, so no priority chain on the data path.
    always_comb begin
        w_mux_data = '0;
        w_mux_sel  = '0;
        for (int i = 0; i < N; i++) begin
            w_mux_data = w_mux_data | (io_bus.in_data[i*W +: W] & {W{w_gnt[i]}});
            w_mux_sel  = w_mux_sel  | (SW'(i) & {SW{w_gnt[i]}});
        end
    end

    assign w_ptr_next = (w_mux_sel == LP_LAST) ? '0 : w_mux_sel + SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_out_sel   <= w_mux_sel;
            if (RR != 0) begin
                r_ptr <= w_ptr_next;
            end
        end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_sel   = r_out_sel;

endmodule
